// File: rtl/conv2d_frame_sequencer_if.sv
// Valid/ready pixel stream with end-of-frame flag, used for the host and
// result sides of the frame sequencer.
interface conv2d_frame_sequencer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         valid;
  logic                         ready;
  logic signed [DATA_WIDTH-1:0] data;
  logic                         last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/conv2d_frame_sequencer.sv
// Frame controller in front of a 1:1 conv2d streaming core: admits exactly one
// frame of host pixels per start, drops incomplete-window border outputs.
module conv2d_frame_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int K          = 3,
  parameter int CNT_W      = $clog2(IMG_W * IMG_H + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_frame_err,
  conv2d_frame_sequencer_if.slave      s_axis,
  output logic                         o_core_in_valid,
  input  logic                         i_core_in_ready,
  output logic signed [DATA_WIDTH-1:0] o_core_in_data,
  input  logic                         i_core_out_valid,
  output logic                         o_core_out_ready,
  input  logic signed [DATA_WIDTH-1:0] i_core_out_data,
  conv2d_frame_sequencer_if.master     m_axis
);

  localparam logic [CNT_W-1:0] LP_N   = CNT_W'(IMG_W * IMG_H);
  localparam logic [CNT_W-1:0] LP_KM1 = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] LP_WM1 = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LP_HM1 = CNT_W'(IMG_H - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_in_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic             r_frame_err;
  logic             r_busy;
  logic             r_done;

  logic             w_run;
  logic             w_active;
  logic             w_keep;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [CNT_W-1:0] w_in_next;
  logic [CNT_W-1:0] w_out_next;
  logic             w_in_final;
  logic             w_out_final;

  assign w_run    = (r_state == StRun);
  assign w_active = (r_state == StRun) || (r_state == StDrain);
  assign w_keep   = (r_row >= LP_KM1) && (r_col >= LP_KM1);

  // Input path: zero-latency pass-through, stalled outside RUN.
  assign o_core_in_valid = s_axis.valid & w_run;
  assign s_axis.ready    = i_core_in_ready & w_run;
  assign o_core_in_data  = s_axis.data;

  // Discarded border outputs are always accepted so they never wait on the sink.
  assign m_axis.valid     = i_core_out_valid & w_keep & w_active;
  assign o_core_out_ready = w_active & (w_keep ? m_axis.ready : 1'b1);
  assign m_axis.data      = i_core_out_data;
  assign m_axis.last      = w_keep && (r_row == LP_HM1) && (r_col == LP_WM1);

  assign w_in_fire   = s_axis.valid & s_axis.ready;
  assign w_out_fire  = i_core_out_valid & o_core_out_ready;
  assign w_in_next   = r_in_cnt + CNT_W'(1);
  assign w_out_next  = r_out_cnt + CNT_W'(1);
  assign w_in_final  = (w_in_next == LP_N);
  assign w_out_final = (w_out_next == LP_N);

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_frame_err = r_frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_in_fire) begin
        r_in_cnt <= w_in_next;
        // Frame length is fixed by count; a misplaced or missing last is only flagged.
        if (s_axis.last != w_in_final) r_frame_err <= 1'b1;
      end
      if (w_out_fire) begin
        r_out_cnt <= w_out_next;
        if (r_col == LP_WM1) begin
          r_col <= '0;
          r_row <= r_row + CNT_W'(1);
        end else begin
          r_col <= r_col + CNT_W'(1);
        end
      end
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state     <= StRun;
            r_busy      <= 1'b1;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_frame_err <= 1'b0;
          end
        end
        StRun: begin
          if (w_in_fire && w_in_final) begin
            if (w_out_fire && w_out_final) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          if (w_out_fire && w_out_final) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_frame_sequencer.sv
// Directed bench: 4x4 frame, K=3, behind a two-stage model of the conv core.
module tb_conv2d_frame_sequencer;
  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int KK = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic o_busy, o_done, o_frame_err;
  logic o_core_in_valid, core_in_ready, core_out_valid, o_core_out_ready;
  logic signed [DW-1:0] o_core_in_data, core_out_data;
  logic core_stall = 1'b0;

  conv2d_frame_sequencer_if #(.DATA_WIDTH(DW)) s_if ();
  conv2d_frame_sequencer_if #(.DATA_WIDTH(DW)) m_if ();

  conv2d_frame_sequencer #(
    .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .K(KK)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_frame_err      (o_frame_err),
    .s_axis           (s_if.slave),
    .o_core_in_valid  (o_core_in_valid),
    .i_core_in_ready  (core_in_ready),
    .o_core_in_data   (o_core_in_data),
    .i_core_out_valid (core_out_valid),
    .o_core_out_ready (o_core_out_ready),
    .i_core_out_data  (core_out_data),
    .m_axis           (m_if.master)
  );

  always #5 clk = ~clk;

  // Identity core modelled as a two-stage pipeline with backpressure.
  logic          p1v, p2v;
  logic [DW-1:0] p1d, p2d;
  logic          s2_acc, s1_acc;
  assign s2_acc         = !p2v || o_core_out_ready;
  assign s1_acc         = !p1v || s2_acc;
  assign core_in_ready  = s1_acc && !core_stall;
  assign core_out_valid = p2v;
  assign core_out_data  = p2d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1v <= 1'b0; p2v <= 1'b0; p1d <= '0; p2d <= '0;
    end else begin
      if (s2_acc) begin p2v <= p1v; p2d <= p1d; end
      if (s1_acc) begin p1v <= o_core_in_valid && core_in_ready; p1d <= o_core_in_data; end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  int kept_d[$];
  int kept_l[$];
  int done_cnt, done_cyc, out16_cyc, outs, disc_bad, stall_bad, busy_bad, timeout;
  int g_pix, g_stall_n;
  bit hold_start = 1'b0;
  int exp_d[4] = '{11, 12, 15, 16};

  task automatic run_frame(input int last_on, input bit tog, input int stall_pix,
                           input int abort_after, input bit no_start);
    int pix = 1;
    int stall_n = 0;
    bit finished = 1'b0;
    kept_d.delete(); kept_l.delete();
    done_cnt = 0; done_cyc = -1; out16_cyc = -100; outs = 0;
    disc_bad = 0; stall_bad = 0; busy_bad = 0; timeout = 0;
    if (!no_start) begin @(negedge clk); i_start = 1'b1; end
    for (int c = 0; c < 300 && !finished; c++) begin
      @(negedge clk);
      i_start = hold_start;
      if (abort_after > 0 && pix > abort_after) begin
        s_if.valid = 1'b0;
        g_pix = pix;
        return;
      end
      m_if.ready = tog ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      core_stall = (pix == stall_pix) && (stall_n < 5);
      if (core_stall) stall_n++;
      s_if.valid = (pix <= 16);
      s_if.data  = DW'(pix);
      s_if.last  = (pix == last_on);
      #1;
      if (c == 0 && !o_busy) busy_bad++;
      if (core_stall && s_if.ready) stall_bad++;
      if (core_out_valid && !m_if.valid && !o_core_out_ready) disc_bad++;
      if (s_if.valid && s_if.ready) pix++;
      if (m_if.valid && m_if.ready) begin
        kept_d.push_back(int'(m_if.data));
        kept_l.push_back(int'(m_if.last));
      end
      if (core_out_valid && o_core_out_ready) begin
        outs++;
        if (outs == 16) out16_cyc = c;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = c;
      end else if (done_cnt > 0) begin
        check_eq("idle_busy_after_done", int'(o_busy), 0);
        finished = 1'b1;
      end
    end
    if (!finished) timeout = 1;
    g_pix = pix;
    g_stall_n = stall_n;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    core_stall = 1'b0;
    m_if.ready = 1'b1;
  endtask

  task automatic verify_frame(input string tag, input int exp_err);
    check_eq({tag, "_timeout"}, timeout, 0);
    check_eq({tag, "_busy_run"}, busy_bad, 0);
    check_eq({tag, "_pix_accepted"}, g_pix - 1, 16);
    check_eq({tag, "_core_outs"}, outs, 16);
    check_eq({tag, "_nkept"}, kept_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < kept_d.size()) begin
        check_eq($sformatf("%s_data%0d", tag, i), kept_d[i], exp_d[i]);
        check_eq($sformatf("%s_last%0d", tag, i), kept_l[i], (i == 3) ? 1 : 0);
      end
    end
    check_eq({tag, "_done_pulses"}, done_cnt, 1);
    check_eq({tag, "_done_latency"}, done_cyc - out16_cyc, 1);
    check_eq({tag, "_discard_ready"}, disc_bad, 0);
    check_eq({tag, "_frame_err"}, int'(o_frame_err), exp_err);
  endtask

  initial begin
    int dn;
    s_if.valid = 1'b0; s_if.data = '0; s_if.last = 1'b0;
    m_if.ready = 1'b1;
    #2;
    check_eq("rst_busy", int'(o_busy), 0);
    check_eq("rst_done", int'(o_done), 0);
    check_eq("rst_frame_err", int'(o_frame_err), 0);
    check_eq("rst_s_ready", int'(s_if.ready), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(16, 1'b0, 0, 0, 1'b0);
    verify_frame("basic", 0);

    run_frame(16, 1'b1, 0, 0, 1'b0);
    verify_frame("toggle", 0);

    run_frame(10, 1'b0, 0, 0, 1'b0);
    verify_frame("early_last", 1);
    repeat (3) @(negedge clk);
    #1;
    check_eq("err_sticky_idle", int'(o_frame_err), 1);

    run_frame(16, 1'b0, 6, 0, 1'b0);
    verify_frame("stall", 0);
    check_eq("stall_ready_low", stall_bad, 0);
    check_eq("stall_cycles", g_stall_n, 5);

    hold_start = 1'b1;
    run_frame(16, 1'b0, 0, 0, 1'b0);
    verify_frame("hold_start", 0);
    hold_start = 1'b0;
    run_frame(16, 1'b0, 0, 0, 1'b1);
    verify_frame("second_frame", 0);

    run_frame(16, 1'b0, 0, 7, 1'b0);
    check_eq("abort_pix", g_pix - 1, 7);
    check_eq("abort_no_done_yet", done_cnt, 0);
    rst = 1'b1;
    #1;
    check_eq("abort_busy", int'(o_busy), 0);
    check_eq("abort_s_ready", int'(s_if.ready), 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      dn += int'(o_done);
    end
    check_eq("abort_done_count", dn, 0);
    check_eq("abort_idle_busy", int'(o_busy), 0);
    run_frame(16, 1'b0, 0, 0, 1'b0);
    verify_frame("post_abort", 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
